scalar_writeback_demux: RTL and testbench

Write-side counterpart of the scalar read-flag mux. It accepts the stream of scalar results (BIT_WIDTH+EXTRA_BIT wide) produced each iteration and writes it into one of two ping-pong RAM buffers. It drives INITIAL_ROM_READ_FLAG and READ_BUF_SEL so that the read path takes ROM data until the first full vector has been written back, then reads from the most recently completed buffer. It sits between the NN datapath output and the two scalar RAM buffers.

---
 rtl/scalar_writeback_demux.sv | 163 ++++++++++++++++
 tb/tb_scalar_writeback_demux.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/scalar_writeback_demux.sv
// scalar_writeback_demux
//
// Writes the per-iteration stream of scalar results into one of two ping-pong
// RAM buffers. It also tells the read side where to fetch scalars from. Until
// the first full vector has been committed, the read path uses ROM
// (INITIAL_ROM_READ_FLAG=1). After that, it reads the most recently completed
// buffer (READ_BUF_SEL).
//
// Handshake: a scalar is accepted in any cycle where SCALAR_VALID and
// SCALAR_READY are both high. SCALAR_READY depends only on the FSM state and
// never on SCALAR_VALID. An accepted scalar appears on BUF_WDATA/BUF_ADDR one
// cycle later, together with a one-cycle write enable for the buffer being
// filled.
//
// Ports:
//   CLK, RST               clock (rising edge), async active-high reset
//   START                  one-cycle pulse: restart the run from ROM
//   SCALAR_IN/VALID/READY  result scalar stream (valid/ready)
//   BUF0_WE, BUF1_WE       per-buffer write enables
//   BUF_ADDR, BUF_WDATA    shared write address / data
//   INITIAL_ROM_READ_FLAG  1 = read path uses ROM output
//   READ_BUF_SEL           buffer the read path uses when the flag is 0
//   VECTOR_DONE            one-cycle pulse when a full vector is committed
//   ITER_COUNT             completed vectors, saturating
//   fsm_state              debug view of the FSM state
module scalar_writeback_demux #(
    parameter int BIT_WIDTH  = 32,
    parameter int EXTRA_BIT  = 2,
    parameter int ADDR_WIDTH = 4,
    parameter int VECTOR_LEN = 10,
    parameter int ITER_WIDTH = 8
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          START,
    input  logic [BIT_WIDTH+EXTRA_BIT-1:0] SCALAR_IN,
    input  logic                          SCALAR_VALID,
    output logic                          SCALAR_READY,
    output logic                          BUF0_WE,
    output logic                          BUF1_WE,
    output logic [ADDR_WIDTH-1:0]         BUF_ADDR,
    output logic [BIT_WIDTH+EXTRA_BIT-1:0] BUF_WDATA,
    output logic                          INITIAL_ROM_READ_FLAG,
    output logic                          READ_BUF_SEL,
    output logic                          VECTOR_DONE,
    output logic [ITER_WIDTH-1:0]         ITER_COUNT,
    output logic [1:0]                    fsm_state
);

    localparam int DW = BIT_WIDTH + EXTRA_BIT;
    localparam logic [ADDR_WIDTH-1:0] LAST_INDEX = ADDR_WIDTH'(VECTOR_LEN - 1);

    if (VECTOR_LEN < 2 || VECTOR_LEN > 2 ** ADDR_WIDTH) begin : g_bad_vector_len
        $error("scalar_writeback_demux: VECTOR_LEN out of range");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        SWAP  = 2'd2
    } state_t;

    state_t                  state, state_n;
    logic                    wsel, wsel_n;
    logic [ADDR_WIDTH-1:0]   index, index_n;
    logic                    we0_n, we1_n;
    logic [ADDR_WIDTH-1:0]   addr_n;
    logic [DW-1:0]           wdata_n;
    logic                    flag_n, rbs_n;
    logic [ITER_WIDTH-1:0]   iter_n;
    logic                    accept;

    assign SCALAR_READY = (state == WRITE);
    assign VECTOR_DONE  = (state == SWAP);
    assign fsm_state    = state;
    assign accept       = SCALAR_VALID && SCALAR_READY;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        wsel_n  = wsel;
        index_n = index;
        we0_n   = 1'b0;
        we1_n   = 1'b0;
        addr_n  = BUF_ADDR;
        wdata_n = BUF_WDATA;
        flag_n  = INITIAL_ROM_READ_FLAG;
        rbs_n   = READ_BUF_SEL;
        iter_n  = ITER_COUNT;
        if (START) begin
            // Restart wins over a same-cycle handshake; that scalar is dropped.
            state_n = WRITE;
            wsel_n  = 1'b0;
            index_n = '0;
            flag_n  = 1'b1;
            rbs_n   = 1'b0;
            iter_n  = '0;
        end else begin
            case (state)
                IDLE: begin
                end
                WRITE: begin
                    if (accept) begin
                        we0_n   = ~wsel;
                        we1_n   = wsel;
                        addr_n  = index;
                        wdata_n = SCALAR_IN;
                        if (index == LAST_INDEX) begin
                            index_n = '0;
                            state_n = SWAP;
                        end else begin
                            index_n = index + ADDR_WIDTH'(1);
                        end
                    end
                end
                SWAP: begin
                    // The last write lands during this cycle, so the read side
                    // switches only once that write has been committed.
                    rbs_n   = wsel;
                    wsel_n  = ~wsel;
                    flag_n  = 1'b0;
                    iter_n  = (ITER_COUNT == '1) ? ITER_COUNT : ITER_COUNT + ITER_WIDTH'(1);
                    state_n = WRITE;
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wsel                  <= 1'b0;
            index                 <= '0;
            BUF0_WE               <= 1'b0;
            BUF1_WE               <= 1'b0;
            BUF_ADDR              <= '0;
            BUF_WDATA             <= '0;
            INITIAL_ROM_READ_FLAG <= 1'b1;
            READ_BUF_SEL          <= 1'b0;
            ITER_COUNT            <= '0;
        end else begin
            wsel                  <= wsel_n;
            index                 <= index_n;
            BUF0_WE               <= we0_n;
            BUF1_WE               <= we1_n;
            BUF_ADDR              <= addr_n;
            BUF_WDATA             <= wdata_n;
            INITIAL_ROM_READ_FLAG <= flag_n;
            READ_BUF_SEL          <= rbs_n;
            ITER_COUNT            <= iter_n;
        end
    end

endmodule

// File: tb/tb_scalar_writeback_demux.sv
// Bench for scalar_writeback_demux with VECTOR_LEN=4 and ITER_WIDTH=2.
// The reference model tracks the number of accepts in the current vector and
// the number of completed vectors. The write buffer, read select, ROM flag and
// iteration count are all derived from the completed-vector count.
module tb_scalar_writeback_demux;

    localparam int BW  = 32;
    localparam int EB  = 2;
    localparam int AW  = 4;
    localparam int VL  = 4;
    localparam int IW  = 2;
    localparam int DW  = BW + EB;
    localparam int SAT = (1 << IW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [DW-1:0] din = '0;
    logic          valid = 1'b0;
    logic          SCALAR_READY, BUF0_WE, BUF1_WE, INITIAL_ROM_READ_FLAG;
    logic          READ_BUF_SEL, VECTOR_DONE;
    logic [AW-1:0] BUF_ADDR;
    logic [DW-1:0] BUF_WDATA;
    logic [IW-1:0] ITER_COUNT;
    logic [1:0]    fsm_state;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state.
    bit            m_running, m_swap;
    int            m_n, m_vecs, m_pend;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;

    scalar_writeback_demux #(
        .BIT_WIDTH(BW), .EXTRA_BIT(EB), .ADDR_WIDTH(AW),
        .VECTOR_LEN(VL), .ITER_WIDTH(IW)
    ) dut (
        .CLK(clk), .RST(rst), .START(start),
        .SCALAR_IN(din), .SCALAR_VALID(valid), .SCALAR_READY(SCALAR_READY),
        .BUF0_WE(BUF0_WE), .BUF1_WE(BUF1_WE),
        .BUF_ADDR(BUF_ADDR), .BUF_WDATA(BUF_WDATA),
        .INITIAL_ROM_READ_FLAG(INITIAL_ROM_READ_FLAG),
        .READ_BUF_SEL(READ_BUF_SEL), .VECTOR_DONE(VECTOR_DONE),
        .ITER_COUNT(ITER_COUNT), .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_running = 0;
        m_swap    = 0;
        m_n       = 0;
        m_vecs    = 0;
        m_pend    = -1;
        m_addr    = '0;
        m_wdata   = '0;
    endtask

    // What the block does at the coming clock edge, given the driven inputs.
    task automatic model_edge();
        if (start) begin
            m_running = 1;
            m_swap    = 0;
            m_n       = 0;
            m_vecs    = 0;
            m_pend    = -1;
        end else if (m_swap) begin
            m_swap = 0;
            m_vecs++;
            m_pend = -1;
        end else if (m_running && valid) begin
            m_pend  = m_vecs % 2;
            m_addr  = AW'(m_n);
            m_wdata = din;
            m_n++;
            if (m_n == VL) begin
                m_n    = 0;
                m_swap = 1;
            end
        end else begin
            m_pend = -1;
        end
    endtask

    task automatic check_outputs();
        int rbs;
        rbs = (m_vecs == 0) ? 0 : (m_vecs - 1) % 2;
        chk("ready", SCALAR_READY, m_running && !m_swap);
        chk("buf0_we", BUF0_WE, m_pend == 0);
        chk("buf1_we", BUF1_WE, m_pend == 1);
        chk("addr", BUF_ADDR, m_addr);
        chk("wdata", BUF_WDATA, m_wdata);
        chk("rom_flag", INITIAL_ROM_READ_FLAG, m_vecs == 0);
        chk("read_sel", READ_BUF_SEL, rbs[0]);
        chk("vector_done", VECTOR_DONE, m_swap);
        chk("iter_count", ITER_COUNT, (m_vecs > SAT) ? SAT : m_vecs);
        if (!INITIAL_ROM_READ_FLAG && (BUF0_WE || BUF1_WE))
            chk("ownership_we_sel", BUF1_WE, !READ_BUF_SEL);
    endtask

    task automatic cycle();
        if (rst) model_reset();
        else model_edge();
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cycle();
        start = 1'b0;
    endtask

    // Feed scalars with valid held high until the block has taken n of them.
    task automatic feed(input int n, input logic [DW-1:0] first);
        int taken;
        taken = 0;
        valid = 1'b1;
        for (int c = 0; c < 4 * n + 8 && taken < n; c++) begin
            din = first + DW'(taken);
            if (SCALAR_READY) taken++;
            cycle();
        end
        chk("feed_count", taken, n);
        valid = 1'b0;
    endtask

    initial begin
        model_reset();
        // Reset held for three cycles, then idle with no START.
        for (int i = 0; i < 3; i++) cycle();
        rst = 1'b0;
        for (int i = 0; i < 20; i++) cycle();

        // First vector 1..4 into buffer 0, then the swap cycle.
        pulse_start();
        feed(VL, DW'(1));
        cycle();
        chk("v1_iter", ITER_COUNT, 1);
        chk("v1_flag", INITIAL_ROM_READ_FLAG, 0);

        // Second vector into buffer 1, third back into buffer 0.
        feed(VL, DW'(5));
        cycle();
        chk("v2_read_sel", READ_BUF_SEL, 1);
        chk("v2_iter", ITER_COUNT, 2);
        feed(VL, DW'(9));
        cycle();

        // Restart after two accepts with a handshake offered in the same cycle.
        feed(2, DW'(32'h20));
        valid = 1'b1;
        din   = DW'(32'h77);
        pulse_start();
        chk("restart_we", {BUF0_WE, BUF1_WE}, 2'b00);
        chk("restart_flag", INITIAL_ROM_READ_FLAG, 1);
        chk("restart_iter", ITER_COUNT, 0);
        din = DW'(32'h30);
        cycle();
        chk("restart_first_we0", BUF0_WE, 1);
        chk("restart_first_addr", BUF_ADDR, 0);
        valid = 1'b0;

        // Random backpressure, data and occasional restarts.
        for (int i = 0; i < 400; i++) begin
            valid = ($urandom_range(0, 99) < 60);
            start = ($urandom_range(0, 99) < 2);
            din   = {2'($urandom_range(0, 3)), 32'($urandom)};
            cycle();
        end
        start = 1'b0;
        valid = 1'b0;

        // Saturation: five full vectors from a fresh start.
        pulse_start();
        for (int v = 0; v < 5; v++) begin
            feed(VL, DW'($urandom));
            cycle();
        end
        chk("iter_saturated", ITER_COUNT, SAT);

        // Asynchronous reset between edges with a write pending.
        feed(2, DW'(32'h55));
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs();
        cycle();
        cycle();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
